// File: rtl/msi_pkg.sv
// Shared types and helpers for the MSI request generator.
// Holds the FSM state encoding and the source-to-vector mapping used by msi_req_gen.
package msi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } msi_state_e;

    localparam int MSI_NUM_W = 5;

    // Sources beyond the allocated vector count all share the last allocated vector.
    function automatic logic [MSI_NUM_W-1:0] msi_vec_map(input logic [MSI_NUM_W-1:0] src,
                                                         input logic [2:0]           mme);
        logic [2:0] mme_c;
        logic [5:0] alloc;
        mme_c = (mme > 3'd5) ? 3'd5 : mme;
        alloc = 6'd1 << mme_c;
        if ({1'b0, src} < alloc) begin
            return src;
        end
        return MSI_NUM_W'(alloc - 6'd1);
    endfunction

endpackage

// File: rtl/msi_req_gen_arb.sv
// Combinational round-robin search: returns the first set request at or after the pointer,
// wrapping around the request vector.
module msi_rr_arb #(
    parameter int N  = 8,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic          valid_o,
    output logic [PW-1:0] idx_o
);

    logic [PW:0] sum;

    // Scan from the farthest offset down so the nearest set bit overwrites the result last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        sum     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            if (req_i[sum[PW-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = sum[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/msi_req_gen.sv
// Turns per-source interrupt pulses into MSI requests on the hard-IP app MSI handshake,
// with round-robin arbitration, vector collapsing and a lost-ack timeout.
module msi_req_gen
    import msi_pkg::*;
#(
    parameter int          NUM_SRC     = 8,
    parameter int          ACK_TIMEOUT = 1024,
    parameter logic [2:0]  MSI_TC      = 3'd0
) (
    input  logic                 iPLD_CLK,
    input  logic                 iRST_N,
    input  logic [15:0]          iCFG_MSICSR,
    input  logic [31:0]          iCFG_PRMCSR,
    input  logic [NUM_SRC-1:0]   iIRQ,
    output logic                 oAPP_MSI_REQ,
    input  logic                 iAPP_MSI_ACK,
    output logic [4:0]           oAPP_MSI_NUM,
    output logic [2:0]           oAPP_MSI_TC,
    output logic [NUM_SRC-1:0]   oPENDING,
    output logic [31:0]          oMSI_CNT,
    output logic                 oTIMEOUT_ERR,
    input  logic                 iCLR_ERR
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT);

    msi_state_e            state_q, state_d;
    logic [NUM_SRC-1:0]    pending_q, pending_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [MSI_NUM_W-1:0]  num_q, num_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  req_q, req_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic                  en;
    logic [2:0]            mme;
    logic                  gnt_valid;
    logic [PW-1:0]         gnt_idx;
    logic                  unused_cfg;

    assign en         = iCFG_MSICSR[0] & iCFG_PRMCSR[2];
    assign mme        = iCFG_MSICSR[6:4];
    assign unused_cfg = ^{iCFG_MSICSR[15:7], iCFG_MSICSR[3:1], iCFG_PRMCSR[31:3], iCFG_PRMCSR[1:0]};

    msi_rr_arb #(
        .N  (NUM_SRC),
        .PW (PW)
    ) u_arb (
        .req_i   (pending_q),
        .ptr_i   (ptr_q),
        .valid_o (gnt_valid),
        .idx_o   (gnt_idx)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | iIRQ;
        ptr_d     = ptr_q;
        num_d     = num_q;
        timer_d   = timer_q;
        req_d     = 1'b0;
        cnt_d     = cnt_q;
        err_d     = err_q & ~iCLR_ERR;

        case (state_q)
            IDLE: begin
                if (en && gnt_valid) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    timer_d = '0;
                    num_d   = msi_vec_map(MSI_NUM_W'(gnt_idx), mme);
                    ptr_d   = (gnt_idx == PW'(NUM_SRC - 1)) ? '0 : gnt_idx + PW'(1);
                end
            end
            REQ: begin
                req_d = 1'b1;
                if (iAPP_MSI_ACK) begin
                    // An event arriving with the ack must survive, so only quiet sources are cleared.
                    for (int j = 0; j < NUM_SRC; j++) begin
                        if ((msi_vec_map(MSI_NUM_W'(j), mme) == num_q) && !iIRQ[j]) begin
                            pending_d[j] = 1'b0;
                        end
                    end
                    cnt_d   = cnt_q + 32'd1;
                    state_d = GAP;
                    req_d   = 1'b0;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = GAP;
                    req_d   = 1'b0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iPLD_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= '0;
            num_q     <= '0;
            timer_q   <= '0;
            req_q     <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            num_q     <= num_d;
            timer_q   <= timer_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign oAPP_MSI_REQ = req_q;
    assign oAPP_MSI_NUM = num_q;
    assign oAPP_MSI_TC  = MSI_TC;
    assign oPENDING     = pending_q;
    assign oMSI_CNT     = cnt_q;
    assign oTIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_msi_req_gen.sv
// Directed self-checking bench for msi_req_gen: enable gating, collapsing, round robin,
// ack timeout, set-wins on ack and asynchronous reset during a request.
module tb_msi_req_gen;

    localparam int NSRC = 8;
    localparam int TOUT = 16;

    logic        clk = 1'b0;
    logic        rstN;
    logic [15:0] msicsr;
    logic [31:0] prmcsr;
    logic [7:0]  irq;
    logic        ack;
    logic        clrErr;
    logic        req;
    logic [4:0]  num;
    logic [2:0]  tc;
    logic [7:0]  pend;
    logic [31:0] cnt;
    logic        err;

    int nChecks = 0;
    int nFails  = 0;

    msi_req_gen #(
        .NUM_SRC     (NSRC),
        .ACK_TIMEOUT (TOUT),
        .MSI_TC      (3'd0)
    ) dut (
        .iPLD_CLK     (clk),
        .iRST_N       (rstN),
        .iCFG_MSICSR  (msicsr),
        .iCFG_PRMCSR  (prmcsr),
        .iIRQ         (irq),
        .oAPP_MSI_REQ (req),
        .iAPP_MSI_ACK (ack),
        .oAPP_MSI_NUM (num),
        .oAPP_MSI_TC  (tc),
        .oPENDING     (pend),
        .oMSI_CNT     (cnt),
        .oTIMEOUT_ERR (err),
        .iCLR_ERR     (clrErr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        irq    = '0;
        ack    = 1'b0;
        clrErr = 1'b0;
        rstN   = 1'b0;
        step();
        step();
        rstN = 1'b1;
        step();
    endtask

    task automatic test_reset();
        msicsr = 16'h0031;
        prmcsr = 32'h4;
        irq    = '0;
        ack    = 1'b0;
        clrErr = 1'b0;
        rstN   = 1'b0;
        step();
        step();
        nChecks++; if (req !== 1'b0) begin nFails++; $display("[TB] FAIL rst_req: got %0h expected 0", req); end
        nChecks++; if (num !== 5'd0) begin nFails++; $display("[TB] FAIL rst_num: got %0h expected 0", num); end
        nChecks++; if (tc !== 3'd0) begin nFails++; $display("[TB] FAIL rst_tc: got %0h expected 0", tc); end
        nChecks++; if (pend !== 8'h00) begin nFails++; $display("[TB] FAIL rst_pend: got %0h expected 0", pend); end
        nChecks++; if (cnt !== 32'd0) begin nFails++; $display("[TB] FAIL rst_cnt: got %0h expected 0", cnt); end
        nChecks++; if (err !== 1'b0) begin nFails++; $display("[TB] FAIL rst_err: got %0h expected 0", err); end
        rstN = 1'b1;
        step();
    endtask

    task automatic test_disabled_then_enabled();
        do_reset();
        msicsr = 16'h0030;
        prmcsr = 32'h4;
        irq = 8'h08;
        step();
        irq = 8'h00;
        nChecks++; if (pend !== 8'h08) begin nFails++; $display("[TB] FAIL dis_pend: got %0h expected 08", pend); end
        step();
        step();
        nChecks++; if (req !== 1'b0) begin nFails++; $display("[TB] FAIL dis_msi_off_req: got %0h expected 0", req); end
        msicsr = 16'h0031;
        prmcsr = 32'h0;
        step();
        step();
        nChecks++; if (req !== 1'b0) begin nFails++; $display("[TB] FAIL dis_bme_off_req: got %0h expected 0", req); end
        nChecks++; if (pend !== 8'h08) begin nFails++; $display("[TB] FAIL dis_pend_held: got %0h expected 08", pend); end
        prmcsr = 32'h4;
        step();
        nChecks++; if (req !== 1'b1) begin nFails++; $display("[TB] FAIL en_req: got %0h expected 1", req); end
        nChecks++; if (num !== 5'd3) begin nFails++; $display("[TB] FAIL en_num: got %0d expected 3", num); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        nChecks++; if (req !== 1'b0) begin nFails++; $display("[TB] FAIL en_ack_req: got %0h expected 0", req); end
        nChecks++; if (pend !== 8'h00) begin nFails++; $display("[TB] FAIL en_ack_pend: got %0h expected 00", pend); end
        nChecks++; if (cnt !== 32'd1) begin nFails++; $display("[TB] FAIL en_ack_cnt: got %0d expected 1", cnt); end
    endtask

    task automatic test_collapsing();
        do_reset();
        msicsr = 16'h0011;
        prmcsr = 32'h4;
        irq = 8'h51;
        step();
        irq = 8'h00;
        nChecks++; if (pend !== 8'h51) begin nFails++; $display("[TB] FAIL col_pend: got %0h expected 51", pend); end
        nChecks++; if (req !== 1'b0) begin nFails++; $display("[TB] FAIL col_latency: got %0h expected 0", req); end
        step();
        nChecks++; if (req !== 1'b1) begin nFails++; $display("[TB] FAIL col_req1: got %0h expected 1", req); end
        nChecks++; if (num !== 5'd0) begin nFails++; $display("[TB] FAIL col_num1: got %0d expected 0", num); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        nChecks++; if (pend !== 8'h50) begin nFails++; $display("[TB] FAIL col_pend1: got %0h expected 50", pend); end
        step();
        step();
        nChecks++; if (req !== 1'b1) begin nFails++; $display("[TB] FAIL col_req2: got %0h expected 1", req); end
        nChecks++; if (num !== 5'd1) begin nFails++; $display("[TB] FAIL col_num2: got %0d expected 1", num); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        nChecks++; if (pend !== 8'h00) begin nFails++; $display("[TB] FAIL col_pend2: got %0h expected 00", pend); end
        nChecks++; if (cnt !== 32'd2) begin nFails++; $display("[TB] FAIL col_cnt: got %0d expected 2", cnt); end
    endtask

    task automatic test_round_robin();
        logic [4:0] expNum[5];
        logic [7:0] expPend[5];
        expNum  = '{5'd1, 5'd2, 5'd6, 5'd0, 5'd1};
        expPend = '{8'h44, 8'h40, 8'h00, 8'h02, 8'h00};
        do_reset();
        msicsr = 16'h0031;
        prmcsr = 32'h4;
        irq = 8'h46;
        step();
        irq = 8'h00;
        step();
        for (int i = 0; i < 5; i++) begin
            nChecks++; if (req !== 1'b1) begin nFails++; $display("[TB] FAIL rr_req%0d: got %0h expected 1", i, req); end
            nChecks++; if (num !== expNum[i]) begin nFails++; $display("[TB] FAIL rr_num%0d: got %0d expected %0d", i, num, expNum[i]); end
            step();
            ack = 1'b1;
            step();
            ack = 1'b0;
            nChecks++; if (pend !== expPend[i]) begin nFails++; $display("[TB] FAIL rr_pend%0d: got %0h expected %0h", i, pend, expPend[i]); end
            if (i == 2) begin
                irq = 8'h03;
            end
            step();
            irq = 8'h00;
            step();
        end
        nChecks++; if (cnt !== 32'd5) begin nFails++; $display("[TB] FAIL rr_cnt: got %0d expected 5", cnt); end
    endtask

    task automatic test_timeout();
        int hiCycles;
        do_reset();
        msicsr = 16'h0031;
        prmcsr = 32'h4;
        irq = 8'h20;
        step();
        irq = 8'h00;
        step();
        nChecks++; if (num !== 5'd5) begin nFails++; $display("[TB] FAIL to_num: got %0d expected 5", num); end
        hiCycles = (req === 1'b1) ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (req !== 1'b1) break;
            hiCycles++;
        end
        nChecks++; if (hiCycles != TOUT) begin nFails++; $display("[TB] FAIL to_req_len: got %0d expected %0d", hiCycles, TOUT); end
        nChecks++; if (err !== 1'b1) begin nFails++; $display("[TB] FAIL to_err: got %0h expected 1", err); end
        nChecks++; if (pend !== 8'h20) begin nFails++; $display("[TB] FAIL to_pend: got %0h expected 20", pend); end
        step();
        step();
        nChecks++; if (req !== 1'b1) begin nFails++; $display("[TB] FAIL to_rereq: got %0h expected 1", req); end
        repeat (TOUT - 1) step();
        clrErr = 1'b1;
        step();
        clrErr = 1'b0;
        nChecks++; if (req !== 1'b0) begin nFails++; $display("[TB] FAIL to_req2_drop: got %0h expected 0", req); end
        nChecks++; if (err !== 1'b1) begin nFails++; $display("[TB] FAIL to_err_wins_clr: got %0h expected 1", err); end
        clrErr = 1'b1;
        step();
        clrErr = 1'b0;
        nChecks++; if (err !== 1'b0) begin nFails++; $display("[TB] FAIL to_clr: got %0h expected 0", err); end
        step();
        nChecks++; if (req !== 1'b1) begin nFails++; $display("[TB] FAIL to_req3: got %0h expected 1", req); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        nChecks++; if (pend !== 8'h00) begin nFails++; $display("[TB] FAIL to_final_pend: got %0h expected 00", pend); end
        nChecks++; if (cnt !== 32'd1) begin nFails++; $display("[TB] FAIL to_final_cnt: got %0d expected 1", cnt); end
    endtask

    task automatic test_ack_at_timeout();
        do_reset();
        msicsr = 16'h0031;
        prmcsr = 32'h4;
        irq = 8'h04;
        step();
        irq = 8'h00;
        step();
        repeat (TOUT - 1) step();
        nChecks++; if (req !== 1'b1) begin nFails++; $display("[TB] FAIL aat_req_last: got %0h expected 1", req); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        nChecks++; if (err !== 1'b0) begin nFails++; $display("[TB] FAIL aat_err: got %0h expected 0", err); end
        nChecks++; if (cnt !== 32'd1) begin nFails++; $display("[TB] FAIL aat_cnt: got %0d expected 1", cnt); end
        nChecks++; if (pend !== 8'h00) begin nFails++; $display("[TB] FAIL aat_pend: got %0h expected 00", pend); end
    endtask

    task automatic test_set_wins();
        do_reset();
        msicsr = 16'h0031;
        prmcsr = 32'h4;
        irq = 8'h04;
        step();
        irq = 8'h00;
        step();
        step();
        ack = 1'b1;
        irq = 8'h04;
        step();
        ack = 1'b0;
        irq = 8'h00;
        nChecks++; if (pend !== 8'h04) begin nFails++; $display("[TB] FAIL sw_pend: got %0h expected 04", pend); end
        nChecks++; if (cnt !== 32'd1) begin nFails++; $display("[TB] FAIL sw_cnt1: got %0d expected 1", cnt); end
        step();
        step();
        nChecks++; if (req !== 1'b1) begin nFails++; $display("[TB] FAIL sw_req2: got %0h expected 1", req); end
        nChecks++; if (num !== 5'd2) begin nFails++; $display("[TB] FAIL sw_num2: got %0d expected 2", num); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        nChecks++; if (pend !== 8'h00) begin nFails++; $display("[TB] FAIL sw_pend2: got %0h expected 00", pend); end
        nChecks++; if (cnt !== 32'd2) begin nFails++; $display("[TB] FAIL sw_cnt2: got %0d expected 2", cnt); end
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        msicsr = 16'h0031;
        prmcsr = 32'h4;
        irq = 8'h02;
        step();
        irq = 8'h00;
        step();
        repeat (TOUT) step();
        step();
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        irq = 8'h80;
        step();
        irq = 8'h00;
        step();
        nChecks++; if (req !== 1'b1) begin nFails++; $display("[TB] FAIL rmr_pre_req: got %0h expected 1", req); end
        nChecks++; if (num !== 5'd7) begin nFails++; $display("[TB] FAIL rmr_pre_num: got %0d expected 7", num); end
        nChecks++; if (err !== 1'b1) begin nFails++; $display("[TB] FAIL rmr_pre_err: got %0h expected 1", err); end
        nChecks++; if (cnt !== 32'd1) begin nFails++; $display("[TB] FAIL rmr_pre_cnt: got %0d expected 1", cnt); end
        #2;
        rstN = 1'b0;
        #1;
        nChecks++; if (req !== 1'b0) begin nFails++; $display("[TB] FAIL rmr_req: got %0h expected 0", req); end
        nChecks++; if (pend !== 8'h00) begin nFails++; $display("[TB] FAIL rmr_pend: got %0h expected 00", pend); end
        nChecks++; if (cnt !== 32'd0) begin nFails++; $display("[TB] FAIL rmr_cnt: got %0d expected 0", cnt); end
        nChecks++; if (err !== 1'b0) begin nFails++; $display("[TB] FAIL rmr_err: got %0h expected 0", err); end
        step();
        rstN = 1'b1;
        repeat (5) step();
        nChecks++; if (req !== 1'b0) begin nFails++; $display("[TB] FAIL rmr_idle_req: got %0h expected 0", req); end
        irq = 8'h01;
        step();
        irq = 8'h00;
        step();
        nChecks++; if (req !== 1'b1) begin nFails++; $display("[TB] FAIL rmr_new_req: got %0h expected 1", req); end
        nChecks++; if (num !== 5'd0) begin nFails++; $display("[TB] FAIL rmr_new_num: got %0d expected 0", num); end
    endtask

    initial begin
        rstN   = 1'b0;
        msicsr = '0;
        prmcsr = '0;
        irq    = '0;
        ack    = 1'b0;
        clrErr = 1'b0;
        test_reset();
        test_disabled_then_enabled();
        test_collapsing();
        test_round_robin();
        test_timeout();
        test_ack_at_timeout();
        test_set_wins();
        test_reset_mid_req();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
